mac_accumulator: RTL and testbench

Downstream stage of the parameterised shift-add multiplier. Takes one M+N-bit product per valid/ready handshake and sums TERMS consecutive products into an ACC_W-bit accumulator. It then presents the sum on an output valid/ready port and holds it until the consumer accepts it. Typical use is dot-product / FIR tap accumulation over the multiplier's product stream.

---
 rtl/mac_accumulator_pkg.sv | 24 ++
 rtl/mac_accumulator_if.sv | 32 +++
 rtl/mac_accumulator_acc_adder.sv | 30 +++
 rtl/mac_accumulator.sv | 125 ++++++++++++
 tb/tb_mac_accumulator.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_accumulator_pkg.sv
// Shared types and helpers for the product accumulator: FSM state encoding
// and the width function used to size the term counter.
package mac_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Bits needed to represent values 0 .. value-1; callers pass TERMS+1
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-in / sum-out handshake bundle between the multiplier stream,
// the accumulator and the result consumer.
interface mac_accumulator_if
   import mac_accumulator_pkg::*;
#(
   parameter int M     = 4,
   parameter int N     = 4,
   parameter int TERMS = 4,
   parameter int ACC_W = 10
);
   localparam int CNT_W = clog2(TERMS + 1);

   logic [M+N-1:0]   prod_in;
   logic             prod_valid;
   logic             prod_ready;
   logic             clr;
   logic [ACC_W-1:0] sum_out;
   logic             sum_valid;
   logic             sum_ready;
   logic             ovf;
   logic [CNT_W-1:0] term_cnt;

   modport master (
      output prod_in, prod_valid, clr, sum_ready,
      input  prod_ready, sum_out, sum_valid, ovf, term_cnt
   );

   modport slave (
      input  prod_in, prod_valid, clr, sum_ready,
      output prod_ready, sum_out, sum_valid, ovf, term_cnt
   );
endinterface

// File: rtl/mac_accumulator_acc_adder.sv
// Accumulator register with a W-bit adder; either loads the addend (first
// term) or adds it to the running value, and exposes the carry out.
module acc_adder #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] addend,
   output logic [W-1:0] sum_next,
   output logic         carry
);
   logic [W-1:0] acc;
   logic [W:0]   full_sum;

   assign full_sum          = load ? {1'b0, addend} : ({1'b0, acc} + {1'b0, addend});
   assign {carry, sum_next} = full_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum_next;
      end
   end
endmodule

// File: rtl/mac_accumulator.sv
// Sums TERMS consecutive products into one result and holds it on the
// output handshake until the consumer takes it.
module mac_accumulator
   import mac_accumulator_pkg::*;
#(
   parameter int M     = 4,
   parameter int N     = 4,
   parameter int TERMS = 4,
   parameter int ACC_W = 10
) (
   input logic            clk,
   input logic            rst_n,
   mac_accumulator_if.slave bus
);
   localparam int CNT_W = clog2(TERMS + 1);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] term_cnt;
   logic [CNT_W-1:0] term_cnt_next;
   logic [CNT_W-1:0] cnt_inc;
   logic [ACC_W-1:0] sum_out;
   logic [ACC_W-1:0] sum_out_next;
   logic [ACC_W-1:0] addend;
   logic [ACC_W-1:0] acc_next;
   logic             sum_valid;
   logic             sum_valid_next;
   logic             ovf;
   logic             ovf_next;
   logic             carry;
   logic             accept;
   logic             release_sum;
   logic             last_term;

   // A product offered alongside clr still handshakes but is thrown away
   assign bus.prod_ready = rst_n && (state != HOLD);
   assign accept         = bus.prod_valid && bus.prod_ready && !bus.clr;
   assign release_sum    = (state == HOLD) && bus.sum_ready;
   assign addend         = ACC_W'(bus.prod_in);
   assign cnt_inc        = term_cnt + CNT_W'(1);
   assign last_term      = (state == IDLE) ? (TERMS == 1) : (cnt_inc == CNT_W'(TERMS));

   acc_adder #(.W(ACC_W)) u_acc_adder (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (bus.clr || release_sum),
      .en       (accept),
      .load     (state == IDLE),
      .addend   (addend),
      .sum_next (acc_next),
      .carry    (carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         term_cnt  <= '0;
         sum_out   <= '0;
         sum_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         state     <= next_state;
         term_cnt  <= term_cnt_next;
         sum_out   <= sum_out_next;
         sum_valid <= sum_valid_next;
         ovf       <= ovf_next;
      end
   end

   always_comb begin
      next_state     = state;
      term_cnt_next  = term_cnt;
      sum_out_next   = sum_out;
      sum_valid_next = sum_valid;
      ovf_next       = ovf;

      if (bus.clr) begin
         next_state     = IDLE;
         term_cnt_next  = '0;
         sum_valid_next = 1'b0;
         ovf_next       = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  term_cnt_next = CNT_W'(1);
                  ovf_next      = 1'b0;
                  next_state    = ACCUM;
                  if (last_term) begin
                     sum_out_next   = acc_next;
                     sum_valid_next = 1'b1;
                     next_state     = HOLD;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  term_cnt_next = cnt_inc;
                  ovf_next      = ovf || carry;
                  if (last_term) begin
                     sum_out_next   = acc_next;
                     sum_valid_next = 1'b1;
                     next_state     = HOLD;
                  end
               end
            end
            HOLD: begin
               if (bus.sum_ready) begin
                  sum_valid_next = 1'b0;
                  term_cnt_next  = '0;
                  next_state     = IDLE;
               end
            end
            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

   assign bus.sum_out   = sum_out;
   assign bus.sum_valid = sum_valid;
   assign bus.ovf       = ovf;
   assign bus.term_cnt  = term_cnt;
endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: a 10-bit instance for the main
// flows and a 9-bit instance for wrap/overflow behaviour.
module tb_mac_accumulator;

   typedef struct packed {
      logic [31:0] sum;
      logic        ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   exp_t        q0[$];
   exp_t        q1[$];
   int          model_cnt[2];
   logic [31:0] model_acc[2];
   logic        model_ovf[2];

   mac_accumulator_if #(.M(4), .N(4), .TERMS(4), .ACC_W(10)) bus0 ();
   mac_accumulator_if #(.M(4), .N(4), .TERMS(4), .ACC_W(9))  bus1 ();

   mac_accumulator #(.M(4), .N(4), .TERMS(4), .ACC_W(10)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   mac_accumulator #(.M(4), .N(4), .TERMS(4), .ACC_W(9)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         model_cnt[i] = 0;
         model_acc[i] = '0;
         model_ovf[i] = 1'b0;
      end
      q0.delete();
      q1.delete();
   endtask

   // Reference behaviour of one accepted product, wrapping at the DUT width
   task automatic model_accept(input int sel, input int value);
      int          width;
      logic [31:0] total;
      exp_t        e;
      width = (sel == 0) ? 10 : 9;
      if (model_cnt[sel] == 0) begin
         model_acc[sel] = 32'(value);
         model_ovf[sel] = 1'b0;
      end else begin
         total = model_acc[sel] + 32'(value);
         if (total >= (32'd1 << width)) model_ovf[sel] = 1'b1;
         model_acc[sel] = total & ((32'd1 << width) - 32'd1);
      end
      model_cnt[sel]++;
      if (model_cnt[sel] == 4) begin
         e.sum = model_acc[sel];
         e.ovf = model_ovf[sel];
         if (sel == 0) q0.push_back(e);
         else          q1.push_back(e);
         model_cnt[sel] = 0;
      end
   endtask

   task automatic apply_stimulus(input int sel, input int value);
      logic rdy;
      bit   done;
      int   waited;
      done   = 0;
      waited = 0;
      if (sel == 0) begin
         bus0.prod_in    = 8'(value);
         bus0.prod_valid = 1'b1;
      end else begin
         bus1.prod_in    = 8'(value);
         bus1.prod_valid = 1'b1;
      end
      while (!done && waited < 50) begin
         @(negedge clk);
         rdy = (sel == 0) ? bus0.prod_ready : bus1.prod_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            done = 1;
            model_accept(sel, value);
         end
         waited++;
      end
      if (!done) check_output("accept_timeout", 32'd0, 32'd1);
      bus0.prod_valid = 1'b0;
      bus1.prod_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pops the expected result whenever a sum is handed to the consumer
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         if (bus0.sum_valid && bus0.sum_ready) begin
            if (q0.size() == 0) check_output("dut0_unexpected_sum", 32'd1, 32'd0);
            else begin
               e = q0.pop_front();
               check_output("dut0_sum", 32'(bus0.sum_out), e.sum);
               check_output("dut0_ovf", 32'(bus0.ovf), 32'(e.ovf));
            end
         end
         if (bus1.sum_valid && bus1.sum_ready) begin
            if (q1.size() == 0) check_output("dut1_unexpected_sum", 32'd1, 32'd0);
            else begin
               e = q1.pop_front();
               check_output("dut1_sum", 32'(bus1.sum_out), e.sum);
               check_output("dut1_ovf", 32'(bus1.ovf), 32'(e.ovf));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      model_reset();
      rst_n           = 1'b0;
      bus0.prod_in    = '0;
      bus0.prod_valid = 1'b0;
      bus0.clr        = 1'b0;
      bus0.sum_ready  = 1'b1;
      bus1.prod_in    = '0;
      bus1.prod_valid = 1'b0;
      bus1.clr        = 1'b0;
      bus1.sum_ready  = 1'b1;

      #3;
      check_output("rst_sum_valid", 32'(bus0.sum_valid), 32'd0);
      check_output("rst_sum_out", 32'(bus0.sum_out), 32'd0);
      check_output("rst_ovf", 32'(bus0.ovf), 32'd0);
      check_output("rst_term_cnt", 32'(bus0.term_cnt), 32'd0);
      #9;
      rst_n = 1'b1;
      #1;
      check_output("rst_prod_ready", 32'(bus0.prod_ready), 32'd1);
      @(posedge clk);
      #1;

      // Basic result: 225+9+24+1 = 259, valid right after the 4th accept edge
      apply_stimulus(0, 225);
      apply_stimulus(0, 9);
      apply_stimulus(0, 24);
      check_output("accum_term_cnt", 32'(bus0.term_cnt), 32'd3);
      apply_stimulus(0, 1);
      check_output("basic_sum_valid", 32'(bus0.sum_valid), 32'd1);
      check_output("basic_term_cnt", 32'(bus0.term_cnt), 32'd4);
      check_output("basic_prod_ready", 32'(bus0.prod_ready), 32'd0);
      @(posedge clk);
      #1;
      check_output("basic_idle_valid", 32'(bus0.sum_valid), 32'd0);
      check_output("basic_idle_ready", 32'(bus0.prod_ready), 32'd1);

      // Consumer stalls: result held, offered product ignored
      bus0.sum_ready = 1'b0;
      for (int i = 1; i <= 4; i++) apply_stimulus(0, i);
      bus0.prod_in    = 8'd99;
      bus0.prod_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_output("hold_sum_valid", 32'(bus0.sum_valid), 32'd1);
         check_output("hold_sum_out", 32'(bus0.sum_out), 32'd10);
         check_output("hold_prod_ready", 32'(bus0.prod_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      bus0.prod_valid = 1'b0;
      bus0.sum_ready  = 1'b1;
      @(posedge clk);
      #1;
      check_output("release_ready", 32'(bus0.prod_ready), 32'd1);
      check_output("release_term_cnt", 32'(bus0.term_cnt), 32'd0);

      // 9-bit instance: 900 wraps to 388 with overflow, then a clean 4
      for (int i = 0; i < 4; i++) apply_stimulus(1, 225);
      for (int i = 0; i < 4; i++) apply_stimulus(1, 1);
      idle_cycles(2);

      // Bubbles between valid beats
      apply_stimulus(0, 3);
      idle_cycles(2);
      apply_stimulus(0, 5);
      idle_cycles(1);
      apply_stimulus(0, 7);
      apply_stimulus(0, 2);
      idle_cycles(2);

      // Abort after two terms; product offered with clr is lost
      apply_stimulus(0, 10);
      apply_stimulus(0, 20);
      bus0.clr        = 1'b1;
      bus0.prod_in    = 8'd50;
      bus0.prod_valid = 1'b1;
      check_output("clr_prod_ready", 32'(bus0.prod_ready), 32'd1);
      @(posedge clk);
      #1;
      bus0.clr        = 1'b0;
      bus0.prod_valid = 1'b0;
      model_cnt[0]    = 0;
      check_output("clr_term_cnt", 32'(bus0.term_cnt), 32'd0);
      check_output("clr_sum_valid", 32'(bus0.sum_valid), 32'd0);
      for (int i = 1; i <= 4; i++) apply_stimulus(0, i);
      idle_cycles(2);

      // Asynchronous reset mid-accumulation, between clock edges
      apply_stimulus(0, 5);
      apply_stimulus(0, 6);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_output("arst_term_cnt", 32'(bus0.term_cnt), 32'd0);
      check_output("arst_sum_out", 32'(bus0.sum_out), 32'd0);
      #1;
      rst_n = 1'b1;
      #1;
      check_output("arst_prod_ready", 32'(bus0.prod_ready), 32'd1);
      @(posedge clk);
      #1;

      // Asynchronous reset while a result is held
      bus0.sum_ready = 1'b0;
      for (int i = 0; i < 4; i++) apply_stimulus(0, 100);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_output("hrst_sum_valid", 32'(bus0.sum_valid), 32'd0);
      check_output("hrst_sum_out", 32'(bus0.sum_out), 32'd0);
      check_output("hrst_term_cnt", 32'(bus0.term_cnt), 32'd0);
      #1;
      rst_n = 1'b1;
      bus0.sum_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 1; i <= 4; i++) apply_stimulus(0, 2 * i);
      idle_cycles(3);

      check_output("q0_drained", 32'(q0.size()), 32'd0);
      check_output("q1_drained", 32'(q1.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
